lcd_seq_ctrl: RTL and testbench
===============================

Name: lcd_seq_ctrl

Overview:
- Write-only sequencer for the board's HD44780-style character LCD. It replaces software bit-banging of the LCD I/O register.
- After reset it runs the mandatory power-up and initialisation command sequence. It then accepts byte-write requests (command or data) over a valid/ready handshake.
- For each byte it generates the RS/RW/EN/DATA bus timing (setup, enable pulse, hold, execution wait).
- Sits between the core's LCD memory-mapped I/O port and the top-level LCD pins.

Parameters:
- T_PWR, 750000, power-up wait in clock cycles before first init command (15 ms at 50 MHz).
- T_SETUP, 2, cycles RS/DATA are stable with EN low before the EN rising edge.
- T_EN, 12, cycles EN is held high.
- T_HOLD, 2, cycles RS/DATA are held after the EN falling edge.
- T_CMD, 2000, execution wait after a normal command or data write (40 us).
- T_LONG, 82000, execution wait after clear/home commands (1.64 ms).

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- req_vld_i  in  1  write request valid.
- req_rdy_o  out  1  controller can accept a request.
- req_rs_i  in  1  0 = command byte, 1 = data byte.
- req_data_i  in  8  byte to write.
- init_done_o  out  1  initialisation sequence complete.
- busy_o  out  1  bus cycle, wait or init in progress.
- lcd_on_o  out  1  LCD power enable.
- lcd_en_o  out  1  LCD enable strobe.
- lcd_rs_o  out  1  LCD register select.
- lcd_rw_o  out  1  LCD read/write; always 0.
- lcd_data_o  out  8  LCD data bus.

Behaviour:
- Clock and reset: one clock domain, clk_i. rst_i is synchronous and active-high.
- Reset values (edge with rst_i=1):
  - state=PWR_WAIT, counter=0.
  - req_rdy_o=0, init_done_o=0, busy_o=1.
  - lcd_on_o=0, lcd_en_o=0, lcd_rs_o=0, lcd_rw_o=0, lcd_data_o=0x00.
- All outputs are registered.
- States: PWR_WAIT, SETUP, PULSE, HOLD, WAIT, IDLE.
- PWR_WAIT:
  - lcd_on_o=1 from the first edge with rst_i=0.
  - Stays for T_PWR cycles, then loads init ROM entry 0 and goes to SETUP.
- Init ROM, all rs=0, in order: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
- SETUP: lcd_rs_o/lcd_data_o driven with the latched byte, lcd_en_o=0, for T_SETUP cycles; then PULSE.
- PULSE: lcd_en_o=1 for T_EN cycles; then HOLD.
- HOLD: lcd_en_o=0, bus unchanged, for T_HOLD cycles; then WAIT.
- WAIT duration:
  - T_LONG cycles if rs=0 and data[7:2]==0 and data!=0 (clear/home commands 0x01–0x03).
  - Otherwise T_CMD cycles.
  - Bus keeps the last value.
- End of WAIT:
  - If init is not finished, advance the ROM index and go to SETUP.
  - After the last ROM entry, set init_done_o=1 (sticky until reset) and go to IDLE.
  - For a user request, go to IDLE.
- IDLE: req_rdy_o=1, busy_o=0. req_rdy_o is 1 only in IDLE with init_done_o=1.
- Handshake:
  - A transfer occurs on an edge where req_vld_i & req_rdy_o.
  - At that edge the controller latches rs/data, drops req_rdy_o, sets busy_o, and enters SETUP.
  - req_vld_i while not ready is ignored (no queue). The requester must hold the request until ready.
- Latency: a request accepted at edge k reasserts req_rdy_o at edge k+T_SETUP+T_EN+T_HOLD+Twait, where Twait is T_CMD or T_LONG.
- Back-to-back: a new request may be accepted on the same edge req_rdy_o is first seen high, i.e. zero idle cycles.
- Reset mid-operation: rst_i=1 at any state returns all outputs to reset values on that edge (EN dropped immediately). Init restarts from PWR_WAIT.
- Counter:
  - One shared down-counter, width $clog2(max of all T_*)+1.
  - Each T_* parameter must be ≥1; a simulation-time assertion fires otherwise.
- lcd_rw_o is tied to 0 in every state; no busy-flag read.

Test Plan:
All scenarios override T_PWR=5, T_SETUP=1, T_EN=3, T_HOLD=1, T_CMD=4, T_LONG=10.
- Reset release: hold rst_i=1 for 3 cycles, then release.
  - During reset: all outputs at reset values, lcd_on_o=0.
  - lcd_on_o=1 after the first low edge.
  - First lcd_en_o rise 6 cycles later, with data 0x38.
- Init sequence completes:
  - Bus shows 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06, each with exactly one 3-cycle EN pulse.
  - init_done_o and req_rdy_o assert 65 cycles after reset release (5 + 5×9 + 15).
- Data write: rs=1, data=0x41 accepted in IDLE.
  - lcd_rs_o=1, lcd_data_o=0x41, one 3-cycle EN pulse, lcd_rw_o=0.
  - req_rdy_o back after 9 cycles.
- Clear command: rs=0, data=0x01.
  - req_rdy_o returns after 15 cycles.
  - Then rs=0, data=0x80 returns after 9 cycles.
- Back-to-back and ignored requests: hold req_vld_i=1 for 3 distinct bytes.
  - Exactly 3 EN pulses, in order, with no lost or duplicated byte.
  - req_vld_i asserted during init or busy causes no transfer.
- Reset mid-pulse: assert rst_i while lcd_en_o=1.
  - On the next edge lcd_en_o=0 and init_done_o=0.
  - Full init re-runs, with init_done_o again 65 cycles after release.

Source files
------------

// File: rtl/lcd_seq_ctrl_if.sv
// Request handshake and LCD pin bundle between the core port, lcd_seq_ctrl and the pins.
// Pure wiring: no latency and no storage; ready/valid backpressure comes from the controller.
// master = requester side (core), slave = lcd_seq_ctrl.
interface lcd_seq_ctrl_if;
    logic       req_vld_i;
    logic       req_rdy_o;
    logic       req_rs_i;
    logic [7:0] req_data_i;
    logic       init_done_o;
    logic       busy_o;
    logic       lcd_on_o;
    logic       lcd_en_o;
    logic       lcd_rs_o;
    logic       lcd_rw_o;
    logic [7:0] lcd_data_o;

    modport master (
        output req_vld_i, req_rs_i, req_data_i,
        input  req_rdy_o, init_done_o, busy_o,
        input  lcd_on_o, lcd_en_o, lcd_rs_o, lcd_rw_o, lcd_data_o
    );

    modport slave (
        input  req_vld_i, req_rs_i, req_data_i,
        output req_rdy_o, init_done_o, busy_o,
        output lcd_on_o, lcd_en_o, lcd_rs_o, lcd_rw_o, lcd_data_o
    );
endinterface

// File: rtl/lcd_seq_ctrl.sv
// HD44780 write sequencer: power-up wait, init ROM, then byte writes with setup/EN/hold/exec timing.
// Latency: accept at edge k, ready again at k+T_SETUP+T_EN+T_HOLD+(T_CMD or T_LONG).
// Backpressure: req_rdy_o high only in IDLE after init; requests seen while not ready are ignored.
module lcd_seq_ctrl #(
    parameter int T_PWR   = 750000,
    parameter int T_SETUP = 2,
    parameter int T_EN    = 12,
    parameter int T_HOLD  = 2,
    parameter int T_CMD   = 2000,
    parameter int T_LONG  = 82000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    lcd_seq_ctrl_if.slave bus
);
    localparam int M0    = (T_PWR > T_SETUP) ? T_PWR : T_SETUP;
    localparam int M1    = (M0 > T_EN) ? M0 : T_EN;
    localparam int M2    = (M1 > T_HOLD) ? M1 : T_HOLD;
    localparam int M3    = (M2 > T_CMD) ? M2 : T_CMD;
    localparam int T_MAX = (M3 > T_LONG) ? M3 : T_LONG;
    localparam int CW    = $clog2(T_MAX) + 1;

    typedef enum logic [2:0] {PWR_WAIT, SETUP, PULSE, HOLD, WAIT, IDLE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    rom_idx;
    logic          long_wait;

    function automatic logic [7:0] rom(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: rom = 8'h38;
            3'd3:             rom = 8'h0C;
            3'd4:             rom = 8'h01;
            default:          rom = 8'h06;
        endcase
    endfunction

    function automatic logic [CW-1:0] ld(input int t);
        ld = CW'(t - 1);
    endfunction

    // The registered bus doubles as the latch for the byte being written.
    assign long_wait = !bus.lcd_rs_o && (bus.lcd_data_o[7:2] == 6'd0) && (bus.lcd_data_o != 8'h00);

    always_ff @(posedge clk_i) begin
        assert (T_PWR >= 1 && T_SETUP >= 1 && T_EN >= 1 && T_HOLD >= 1 && T_CMD >= 1 && T_LONG >= 1)
            else $error("lcd_seq_ctrl: every T_* parameter must be >= 1");
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= PWR_WAIT;
            cnt             <= '0;
            rom_idx         <= '0;
            bus.req_rdy_o   <= 1'b0;
            bus.init_done_o <= 1'b0;
            bus.busy_o      <= 1'b1;
            bus.lcd_on_o    <= 1'b0;
            bus.lcd_en_o    <= 1'b0;
            bus.lcd_rs_o    <= 1'b0;
            bus.lcd_rw_o    <= 1'b0;
            bus.lcd_data_o  <= 8'h00;
        end else begin
            bus.lcd_rw_o <= 1'b0;
            case (state)
                PWR_WAIT: begin
                    // lcd_on_o low marks the first edge out of reset, where the wait is armed.
                    if (!bus.lcd_on_o) begin
                        bus.lcd_on_o <= 1'b1;
                        cnt          <= ld(T_PWR);
                    end else if (cnt == '0) begin
                        state          <= SETUP;
                        rom_idx        <= 3'd0;
                        bus.lcd_rs_o   <= 1'b0;
                        bus.lcd_data_o <= rom(3'd0);
                        cnt            <= ld(T_SETUP);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state        <= PULSE;
                        bus.lcd_en_o <= 1'b1;
                        cnt          <= ld(T_EN);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        state        <= HOLD;
                        bus.lcd_en_o <= 1'b0;
                        cnt          <= ld(T_HOLD);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state <= WAIT;
                        cnt   <= long_wait ? ld(T_LONG) : ld(T_CMD);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!bus.init_done_o && rom_idx != 3'd5) begin
                        state          <= SETUP;
                        rom_idx        <= rom_idx + 3'd1;
                        bus.lcd_data_o <= rom(rom_idx + 3'd1);
                        cnt            <= ld(T_SETUP);
                    end else begin
                        state           <= IDLE;
                        bus.init_done_o <= 1'b1;
                        bus.req_rdy_o   <= 1'b1;
                        bus.busy_o      <= 1'b0;
                    end
                end
                IDLE: begin
                    if (bus.req_vld_i && bus.req_rdy_o) begin
                        state          <= SETUP;
                        bus.lcd_rs_o   <= bus.req_rs_i;
                        bus.lcd_data_o <= bus.req_data_i;
                        bus.req_rdy_o  <= 1'b0;
                        bus.busy_o     <= 1'b1;
                        cnt            <= ld(T_SETUP);
                    end
                end
                default: state <= PWR_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Randomised scoreboard bench for lcd_seq_ctrl with shortened timing parameters.
module tb_lcd_seq_ctrl;
    localparam int T_PWR = 5, T_SETUP = 1, T_EN = 3, T_HOLD = 1, T_CMD = 4, T_LONG = 10;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    lcd_seq_ctrl_if bus();

    lcd_seq_ctrl #(
        .T_PWR(T_PWR), .T_SETUP(T_SETUP), .T_EN(T_EN),
        .T_HOLD(T_HOLD), .T_CMD(T_CMD), .T_LONG(T_LONG)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } wr_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    wr_t exp_wr[$];
    int  exp_rdy[$];
    wr_t w;
    int  en_rise_cyc = 0;
    int  rel_base    = 0;
    bit  want_first  = 1'b0;

    logic [7:0] init_seq [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Reference timing: one bus cycle plus the execution wait the LCD needs for this byte.
    function automatic int lat(input logic rs, input logic [7:0] d);
        return T_SETUP + T_EN + T_HOLD + ((!rs && d >= 8'd1 && d <= 8'd3) ? T_LONG : T_CMD);
    endfunction

    // Monitor: compare every EN pulse and every ready rise against the queued expectations.
    logic       prev_en  = 1'b0;
    logic       prev_rdy = 1'b0;
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (bus.lcd_en_o && !prev_en) begin
                check("en_rw", bus.lcd_rw_o, 0);
                if (exp_wr.size() == 0) begin
                    fail("unexpected_write");
                end else begin
                    w = exp_wr.pop_front();
                    check("wr_rs", bus.lcd_rs_o, w.rs);
                    check("wr_data", bus.lcd_data_o, w.data);
                end
                if (want_first) begin
                    check("first_en_cycle", cyc - rel_base, T_PWR + T_SETUP);
                    want_first = 1'b0;
                end
                en_rise_cyc = cyc;
            end
            if (!bus.lcd_en_o && prev_en)
                check("en_width", cyc - en_rise_cyc, T_EN);
            if (bus.req_rdy_o && !prev_rdy) begin
                check("rdy_busy", bus.busy_o, 0);
                check("rdy_init_done", bus.init_done_o, 1);
                if (exp_rdy.size() == 0) fail("unexpected_rdy");
                else check("rdy_cycle", cyc, exp_rdy.pop_front());
            end
        end
        prev_en  = bus.lcd_en_o;
        prev_rdy = bus.req_rdy_o;
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_rdy"},  bus.req_rdy_o, 0);
        check({tag, "_done"}, bus.init_done_o, 0);
        check({tag, "_busy"}, bus.busy_o, 1);
        check({tag, "_on"},   bus.lcd_on_o, 0);
        check({tag, "_en"},   bus.lcd_en_o, 0);
        check({tag, "_rs"},   bus.lcd_rs_o, 0);
        check({tag, "_rw"},   bus.lcd_rw_o, 0);
        check({tag, "_data"}, bus.lcd_data_o, 0);
    endtask

    // Called at a negedge: releases reset and queues the full init expectation.
    task automatic do_release();
        int total;
        rst_i    = 1'b0;
        rel_base = cyc + 1;
        total    = T_PWR;
        for (int i = 0; i < 6; i++) begin
            exp_wr.push_back({1'b0, init_seq[i]});
            total += lat(1'b0, init_seq[i]);
        end
        exp_rdy.push_back(rel_base + total);
        want_first = 1'b1;
        @(negedge clk_i);
        check("on_after_release", bus.lcd_on_o, 1);
        check("busy_after_release", bus.busy_o, 1);
    endtask

    // Called at a negedge. hold=1 keeps the real request on the bus while waiting;
    // hold=0 drives random junk until ready, which must never be taken.
    task automatic send(input logic rs, input logic [7:0] d, input bit hold);
        int budget = 0;
        forever begin
            if (bus.req_rdy_o) begin
                bus.req_vld_i  = 1'b1;
                bus.req_rs_i   = rs;
                bus.req_data_i = d;
                @(posedge clk_i);
                #1;
                exp_wr.push_back({rs, d});
                exp_rdy.push_back(cyc + lat(rs, d));
                @(negedge clk_i);
                bus.req_vld_i = 1'b0;
                return;
            end
            if (hold) begin
                bus.req_vld_i  = 1'b1;
                bus.req_rs_i   = rs;
                bus.req_data_i = d;
            end else begin
                bus.req_vld_i  = 1'($urandom_range(0, 1));
                bus.req_rs_i   = 1'($urandom);
                bus.req_data_i = 8'($urandom);
            end
            budget++;
            if (budget > 300) begin
                bus.req_vld_i = 1'b0;
                fail("send_timeout");
                return;
            end
            @(negedge clk_i);
        end
    endtask

    initial begin
        logic       rs;
        logic [7:0] d;
        int         n;
        bus.req_vld_i  = 1'b0;
        bus.req_rs_i   = 1'b0;
        bus.req_data_i = 8'h00;

        repeat (3) @(negedge clk_i);
        check_reset_vals("reset");
        do_release();

        // Junk requests during init must be ignored.
        send(1'b1, 8'h41, 1'b0);
        send(1'b0, 8'h01, 1'b0);
        send(1'b0, 8'h80, 1'b0);

        // Back-to-back with the request held.
        send(1'b1, 8'h52, 1'b1);
        send(1'b1, 8'h53, 1'b1);
        send(1'b1, 8'h54, 1'b1);

        for (int i = 0; i < 25; i++) begin
            rs = 1'($urandom);
            d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            send(rs, d, 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
        end

        // Reset while EN is high.
        send(1'b1, 8'h5A, 1'b1);
        n = 0;
        while (!bus.lcd_en_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        if (!bus.lcd_en_o) fail("en_never_rose");
        rst_i = 1'b1;
        @(negedge clk_i);
        exp_wr.delete();
        exp_rdy.delete();
        check_reset_vals("midrst");
        @(negedge clk_i);
        do_release();
        send(1'b0, 8'h02, 1'b0);
        send(1'b1, 8'h7E, 1'b1);

        n = 0;
        while ((exp_rdy.size() != 0 || exp_wr.size() != 0) && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        if (exp_rdy.size() != 0 || exp_wr.size() != 0) fail("drain_timeout");
        @(negedge clk_i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
